// File: rtl/qsys_system_niosii_cpu_ocimem_pkg.sv
// Shared constants for the OCI debug-memory controller: jdo field map and FSM encoding.
package qsys_system_niosii_cpu_ocimem_pkg;

  localparam int unsigned JDO_W        = 38;
  localparam int unsigned JDO_ADDR_LSB = 17;
  localparam int unsigned JDO_RDLOAD   = 36;
  localparam int unsigned JDO_WR       = 35;
  localparam int unsigned JDO_DATA_MSB = 34;
  localparam int unsigned JDO_DATA_LSB = 3;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BE_W         = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_J_RD = 2'd1;
  localparam logic [1:0] ST_C_RD = 2'd2;

endpackage

// File: rtl/qsys_system_niosii_cpu_ocimem_ram.sv
// Single-port debug RAM: 1-cycle synchronous read, byte-enable write, contents not reset.
module qsys_system_niosii_cpu_ocimem_ram
  import qsys_system_niosii_cpu_ocimem_pkg::*;
#(
  parameter int unsigned AW   = 8,
  parameter string       INIT = ""
) (
  input  logic              clk,
  input  logic [AW-1:0]     address,
  input  logic              wren,
  input  logic [BE_W-1:0]   byteena,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  // Named anchor for the device flow that binds the init image to this array.
  if (INIT != "") begin : g_init_image
  end

  // Byte-lane write and registered read (read-during-write returns old data).
  always_ff @(posedge clk) begin
    if (wren) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (byteena[b]) mem[address][8*b +: 8] <= data[8*b +: 8];
      end
    end
    q <= mem[address];
  end

endmodule

// File: rtl/qsys_system_niosii_cpu_ocimem_ctrl.sv
// Sysclk-side executor of JTAG debug-memory ops, arbitrated against the CPU's debug slave.
module qsys_system_niosii_cpu_ocimem_ctrl
  import qsys_system_niosii_cpu_ocimem_pkg::*;
#(
  parameter int unsigned AW   = 8,
  parameter string       INIT = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [AW-1:0]     avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [BE_W-1:0]   avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              mon_busy
);

  logic [1:0]        state, state_n;
  logic [AW-1:0]     jaddr, jaddr_n;
  logic [DATA_W-1:0] mon_n;

  // Pending strobes and the jdo fields latched with them
  logic              pend_a, pend_b, pend_na;
  logic              pend_a_n, pend_b_n, pend_na_n;
  logic [AW-1:0]     la_addr;
  logic              la_rd;
  logic              lb_wr;
  logic [DATA_W-1:0] lb_data;

  logic              acc_a, acc_b, acc_na;
  logic              eff_a, eff_b, eff_na;
  logic [AW-1:0]     a_addr;
  logic              a_rd, b_wr;
  logic [DATA_W-1:0] b_data;
  logic              serve_a, serve_b, serve_na, cpu_done;

  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_d, ram_q;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_DATA_LSB-1:0]};

  // Same-cycle strobe priority a > b > no_action_a; losers are dropped
  assign acc_a  = take_action_ocimem_a;
  assign acc_b  = take_action_ocimem_b & ~take_action_ocimem_a;
  assign acc_na = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

  assign eff_a  = acc_a  | pend_a;
  assign eff_b  = acc_b  | pend_b;
  assign eff_na = acc_na | pend_na;

  // A fresh strobe's jdo takes precedence over an older latched copy
  assign a_addr = acc_a ? jdo[JDO_ADDR_LSB +: AW] : la_addr;
  assign a_rd   = acc_a ? jdo[JDO_RDLOAD] : la_rd;
  assign b_wr   = acc_b ? jdo[JDO_WR] : lb_wr;
  assign b_data = acc_b ? jdo[JDO_DATA_MSB:JDO_DATA_LSB] : lb_data;

  assign pend_a_n  = (pend_a  | acc_a)  & ~serve_a;
  assign pend_b_n  = (pend_b  | acc_b)  & ~serve_b;
  assign pend_na_n = (pend_na | acc_na) & ~serve_na;

  assign avs_readdata    = ram_q;
  assign avs_waitrequest = avs_chipselect & (avs_read | avs_write) & ~cpu_done;

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      jaddr    <= '0;
      MonDReg  <= '0;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      pend_na  <= 1'b0;
      la_addr  <= '0;
      la_rd    <= 1'b0;
      lb_wr    <= 1'b0;
      lb_data  <= '0;
      mon_busy <= 1'b0;
    end else begin
      state    <= state_n;
      jaddr    <= jaddr_n;
      MonDReg  <= mon_n;
      pend_a   <= pend_a_n;
      pend_b   <= pend_b_n;
      pend_na  <= pend_na_n;
      mon_busy <= pend_a_n | pend_b_n | pend_na_n | (state_n == ST_J_RD);
      if (acc_a) begin
        la_addr <= jdo[JDO_ADDR_LSB +: AW];
        la_rd   <= jdo[JDO_RDLOAD];
      end
      if (acc_b) begin
        lb_wr   <= jdo[JDO_WR];
        lb_data <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
      end
    end
  end

  // Next-state, RAM port steering and arbitration (JTAG always ahead of CPU)
  always_comb begin
    state_n  = state;
    jaddr_n  = jaddr;
    mon_n    = MonDReg;
    ram_addr = jaddr;
    ram_we   = 1'b0;
    ram_be   = {BE_W{1'b1}};
    ram_d    = b_data;
    serve_a  = 1'b0;
    serve_b  = 1'b0;
    serve_na = 1'b0;
    cpu_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (eff_a) begin
          serve_a  = 1'b1;
          jaddr_n  = a_addr;
          ram_addr = a_addr;
          if (a_rd) state_n = ST_J_RD;
        end else if (eff_b) begin
          serve_b = 1'b1;
          jaddr_n = jaddr + AW'(1);
          if (b_wr) ram_we  = 1'b1;
          else      state_n = ST_J_RD;
        end else if (eff_na) begin
          serve_na = 1'b1;
          state_n  = ST_J_RD;
        end else if (avs_chipselect && avs_write) begin
          cpu_done = 1'b1;
          ram_addr = avs_address;
          ram_we   = avs_debugaccess;
          ram_be   = avs_byteenable;
          ram_d    = avs_writedata;
        end else if (avs_chipselect && avs_read) begin
          ram_addr = avs_address;
          state_n  = ST_C_RD;
        end
      end
      ST_J_RD: begin
        mon_n   = ram_q;
        state_n = ST_IDLE;
      end
      ST_C_RD: begin
        cpu_done = avs_chipselect & avs_read;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  qsys_system_niosii_cpu_ocimem_ram #(.AW(AW), .INIT(INIT)) u_ram (
    .clk     (clk),
    .address (ram_addr),
    .wren    (ram_we),
    .byteena (ram_be),
    .data    (ram_d),
    .q       (ram_q)
  );

endmodule

// File: tb/tb_qsys_system_niosii_cpu_ocimem_ctrl.sv
// Directed self-checking bench for the OCI debug-memory controller.
module tb_qsys_system_niosii_cpu_ocimem_ctrl;

  localparam int unsigned AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_b, take_na;
  logic [AW-1:0] avs_address;
  logic        avs_chipselect, avs_read, avs_write, avs_debugaccess;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata, MonDReg;
  logic        avs_waitrequest, mon_busy;

  int passed = 0;
  int total  = 0;
  logic [31:0] rd;
  int lat;

  always #5 clk = ~clk;

  qsys_system_niosii_cpu_ocimem_ctrl #(.AW(AW), .INIT("")) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .avs_address             (avs_address),
    .avs_chipselect          (avs_chipselect),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .mon_busy                (mon_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic [AW-1:0] addr, input logic rdl);
    logic [37:0] j;
    j = '0;
    j[17 +: AW] = addr;
    j[36] = rdl;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic wr, input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[35] = wr;
    j[34:3] = d;
    return j;
  endfunction

  task automatic wait_jtag(input string tag);
    int n;
    n = 0;
    while (mon_busy && n < 16) begin
      tick();
      n++;
    end
    chk(tag, 32'(mon_busy), 32'd0);
  endtask

  task automatic jtag_a(input logic [AW-1:0] addr, input logic rdl);
    jdo = mk_a(addr, rdl); take_a = 1'b1;
    tick();
    take_a = 1'b0; jdo = '0;
    wait_jtag("jtag_a_done");
  endtask

  task automatic jtag_b(input logic wr, input logic [31:0] d);
    jdo = mk_b(wr, d); take_b = 1'b1;
    tick();
    take_b = 1'b0; jdo = '0;
    wait_jtag("jtag_b_done");
  endtask

  task automatic jtag_na();
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    wait_jtag("jtag_na_done");
  endtask

  task automatic cpu_read(input logic [AW-1:0] addr, output logic [31:0] d, output int cycles);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = addr;
    #1;
    cycles = 1;
    while (avs_waitrequest && cycles < 20) begin
      tick();
      cycles++;
    end
    d = avs_readdata;
    tick();
    avs_chipselect = 1'b0; avs_read = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] addr, input logic [31:0] d,
                           input logic [3:0] be, input logic dbg);
    int n;
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = addr;
    avs_writedata = d; avs_byteenable = be; avs_debugaccess = dbg;
    #1;
    n = 0;
    while (avs_waitrequest && n < 20) begin
      tick();
      n++;
    end
    chk("cpu_wr_stall", 32'(n), 32'd0);
    tick();
    avs_chipselect = 1'b0; avs_write = 1'b0; avs_debugaccess = 1'b0;
  endtask

  initial begin
    reset = 1'b1; jdo = '0; take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    avs_address = '0; avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = 4'hF; avs_debugaccess = 1'b0;
    tick(); tick();
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_busy", 32'(mon_busy), 32'd0);
    chk("rst_wait", 32'(avs_waitrequest), 32'd0);
    reset = 1'b0;
    tick();

    // 1: JTAG write to 5, CPU reads it back with 2-cycle latency
    jtag_a(8'd5, 1'b0);
    chk("t1_a_norun_busy", 32'(mon_busy), 32'd0);
    jtag_b(1'b1, 32'hDEADBEEF);
    cpu_read(8'd5, rd, lat);
    chk("t1_rd5", rd, 32'hDEADBEEF);
    chk("t1_lat", 32'(lat), 32'd2);

    // 2: post-increment wraps from top address to 0
    jtag_a(8'hFF, 1'b0);
    jtag_b(1'b1, 32'h1);
    jtag_b(1'b1, 32'h2);
    cpu_read(8'd0, rd, lat);
    chk("t2_rd0", rd, 32'h2);
    cpu_read(8'hFF, rd, lat);
    chk("t2_rdff", rd, 32'h1);

    // 3: debugaccess gate and byte enables on CPU writes
    jtag_a(8'd9, 1'b0);
    jtag_b(1'b1, 32'hCAFEF00D);
    cpu_write(8'd9, 32'h12345678, 4'hF, 1'b0);
    cpu_read(8'd9, rd, lat);
    chk("t3_nodbg", rd, 32'hCAFEF00D);
    cpu_write(8'd9, 32'h12345678, 4'b0011, 1'b1);
    cpu_read(8'd9, rd, lat);
    chk("t3_be", rd, 32'hCAFE5678);
    jtag_a(8'd9, 1'b1);
    chk("t3_jrd", MonDReg, 32'hCAFE5678);

    // 4: CPU read and JTAG load-with-read in the same cycle; JTAG wins
    cpu_write(8'd3, 32'hA5A50003, 4'hF, 1'b1);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 8'd5;
    jdo = mk_a(8'd3, 1'b1); take_a = 1'b1;
    #1;
    chk("t4_wait0", 32'(avs_waitrequest), 32'd1);
    tick();
    take_a = 1'b0; jdo = '0;
    chk("t4_busy", 32'(mon_busy), 32'd1);
    chk("t4_wait1", 32'(avs_waitrequest), 32'd1);
    chk("t4_mon_hold", MonDReg, 32'hCAFE5678);
    tick();
    chk("t4_mon", MonDReg, 32'hA5A50003);
    chk("t4_wait2", 32'(avs_waitrequest), 32'd1);
    tick();
    chk("t4_wait3", 32'(avs_waitrequest), 32'd0);
    chk("t4_cpu_rd", avs_readdata, 32'hDEADBEEF);
    tick();
    avs_chipselect = 1'b0; avs_read = 1'b0;

    // 5: a+b same cycle executes only a; no_action re-reads without increment
    jtag_a(8'd7, 1'b0);
    jtag_b(1'b1, 32'h77777777);
    jtag_b(1'b1, 32'h88888888);
    jdo = mk_a(8'd7, 1'b0); jdo[35] = 1'b1;
    take_a = 1'b1; take_b = 1'b1;
    tick();
    take_a = 1'b0; take_b = 1'b0; jdo = '0;
    chk("t5_b_dropped", 32'(mon_busy), 32'd0);
    jtag_na();
    chk("t5_na", MonDReg, 32'h77777777);
    jtag_b(1'b0, 32'h0);
    chk("t5_b_rd", MonDReg, 32'h77777777);
    jtag_na();
    chk("t5_na_inc", MonDReg, 32'h88888888);
    cpu_read(8'd7, rd, lat);
    chk("t5_nowrite", rd, 32'h77777777);

    // 5b: JTAG strobe arriving during C_RD is held and served afterwards
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 8'd5;
    #1;
    tick();
    chk("t5b_cpu_rd", avs_readdata, 32'hDEADBEEF);
    chk("t5b_wait", 32'(avs_waitrequest), 32'd0);
    jdo = mk_a(8'd3, 1'b1); take_a = 1'b1;
    tick();
    take_a = 1'b0; jdo = '0; avs_chipselect = 1'b0; avs_read = 1'b0;
    chk("t5b_pending", 32'(mon_busy), 32'd1);
    chk("t5b_mon_hold", MonDReg, 32'h88888888);
    wait_jtag("t5b_done");
    chk("t5b_mon", MonDReg, 32'hA5A50003);

    // 6: async reset while in J_RD
    jdo = mk_a(8'd9, 1'b1); take_a = 1'b1;
    tick();
    take_a = 1'b0; jdo = '0;
    chk("t6_in_jrd", 32'(mon_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_mon", MonDReg, 32'h0);
    chk("t6_rst_busy", 32'(mon_busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_mon_stay", MonDReg, 32'h0);
    cpu_read(8'd5, rd, lat);
    chk("t6_ram_kept", rd, 32'hDEADBEEF);
    chk("t6_lat", 32'(lat), 32'd2);
    jtag_na();
    chk("t6_jaddr0", MonDReg, 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
